// File: rtl/conv_bias_lrelu_stage.sv
// Post-convolution stage: per-frame bias add, LeakyReLU, 16-bit saturation, TLAST framing check.
// Two-stage valid/ready pipeline re-streaming activated pixels toward the DMA.
module conv_bias_lrelu_stage #(
    parameter int unsigned IMG_W      = 128,
    parameter int unsigned IMG_H      = 128,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic [15:0] cfg_bias,
    output logic        frame_done,
    output logic        err_tlast,
    output logic [15:0] sat_count
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

    logic               ready_en_q;
    logic               v1_q, v2_q;
    logic signed [16:0] sum1_q;
    logic               last1_q, fs1_q;
    logic [15:0]        bias_q;
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [15:0]        data2_q;
    logic               last2_q;
    logic [15:0]        sat_cnt_q;
    logic               err_q;
    logic               fd_q;

    logic               rdy1, rdy2, s_xfer;
    logic               frame_start, at_last;
    logic [15:0]        bias_sel;
    logic signed [16:0] sum_d;
    logic signed [16:0] shifted, act;
    logic [15:0]        act_sat;
    logic               sat_hit;
    logic [15:0]        sat_cnt_d;

    // ready_en_q keeps the input closed until the first edge after reset release
    assign rdy2          = !v2_q || m_axis_tready;
    assign rdy1          = ready_en_q && (!v1_q || rdy2);
    assign s_axis_tready = rdy1;
    assign s_xfer        = s_axis_tvalid && rdy1;

    assign frame_start = (col_q == '0) && (row_q == '0);
    assign at_last     = (col_q == ColLast) && (row_q == RowLast);
    assign bias_sel    = frame_start ? cfg_bias : bias_q;
    assign sum_d       = {s_axis_tdata[15], s_axis_tdata} + {bias_sel[15], bias_sel};

    assign shifted = sum1_q >>> LEAK_SHIFT;

    always_comb begin
        act     = sum1_q[16] ? shifted : sum1_q;
        act_sat = act[15:0];
        sat_hit = 1'b0;
        if (!act[16] && act[15]) begin
            act_sat = 16'h7FFF;
            sat_hit = 1'b1;
        end else if (act[16] && !act[15]) begin
            act_sat = 16'h8000;
            sat_hit = 1'b1;
        end
    end

    // The frame-start beat restarts the count with its own flag
    always_comb begin
        if (fs1_q) begin
            sat_cnt_d = {15'd0, sat_hit};
        end else if (sat_cnt_q == 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q;
        end else begin
            sat_cnt_d = sat_cnt_q + {15'd0, sat_hit};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            sum1_q     <= '0;
            last1_q    <= 1'b0;
            fs1_q      <= 1'b0;
            bias_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            data2_q    <= '0;
            last2_q    <= 1'b0;
            sat_cnt_q  <= '0;
            err_q      <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;

            if (s_xfer) begin
                if (frame_start) bias_q <= cfg_bias;
                if (s_axis_tlast != at_last) err_q <= 1'b1;
                // An early TLAST resyncs the raster to the next frame start
                if (s_axis_tlast || at_last) begin
                    col_q <= '0;
                    row_q <= '0;
                end else if (col_q == ColLast) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (rdy1) begin
                v1_q <= s_xfer;
                if (s_xfer) begin
                    sum1_q  <= sum_d;
                    last1_q <= s_axis_tlast || at_last;
                    fs1_q   <= frame_start;
                end
            end

            if (rdy2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    data2_q   <= act_sat;
                    last2_q   <= last1_q;
                    sat_cnt_q <= sat_cnt_d;
                end
            end

            fd_q <= v2_q && m_axis_tready && last2_q;
        end
    end

    assign m_axis_tvalid = v2_q;
    assign m_axis_tdata  = data2_q;
    assign m_axis_tlast  = last2_q;
    assign frame_done    = fd_q;
    assign err_tlast     = err_q;
    assign sat_count     = sat_cnt_q;

endmodule

// File: tb/tb_conv_bias_lrelu_stage.sv
// Directed bench for conv_bias_lrelu_stage: hand-checked vectors plus a reference model
// scoreboard that follows every beat through the pipeline.
module tb_conv_bias_lrelu_stage;

    localparam int W    = 128;
    localparam int H    = 128;
    localparam int LS   = 3;
    localparam int NPIX = W * H;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [15:0] cfg_bias = '0;
    logic        frame_done;
    logic        err_tlast;
    logic [15:0] sat_count;

    always #5 aclk = ~aclk;

    conv_bias_lrelu_stage #(
        .IMG_W     (W),
        .IMG_H     (H),
        .LEAK_SHIFT(LS)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .cfg_bias     (cfg_bias),
        .frame_done   (frame_done),
        .err_tlast    (err_tlast),
        .sat_count    (sat_count)
    );

    int ncmp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {sat, data}
    function automatic logic [16:0] ref_pix(input logic [15:0] d, input logic [15:0] b);
        int s;
        s = int'($signed(d)) + int'($signed(b));
        if (s < 0) s = s >>> LS;
        if (s > 32767) return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, s[15:0]};
    endfunction

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [15:0] sat;
    } exp_t;

    exp_t        q[$];
    int          mcol = 0, mrow = 0;
    logic [15:0] mbias = '0, msat = '0;
    logic        merr = 1'b0;
    logic        pend_fd = 1'b0, stall_pend = 1'b0;
    logic [15:0] stall_data = '0;
    logic        stall_last = 1'b0;
    int          n_out = 0, n_last = 0, n_fd = 0;
    logic [15:0] last_out = '0;
    logic        chk_rdy = 1'b0;
    logic        bp_mode = 1'b0;

    always @(posedge aclk) begin
        #1;
        m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard: sampled mid-cycle, acts on the transfers the next edge will perform
    always @(negedge aclk) begin
        if (!aresetn) begin
            q.delete();
            mcol = 0; mrow = 0; mbias = '0; msat = '0; merr = 1'b0;
            pend_fd = 1'b0; stall_pend = 1'b0;
        end else begin
            exp_t e;
            logic [16:0] r;
            logic at_last;
            if (chk_rdy) check("s_ready", 32'(s_axis_tready), 32'((q.size() < 2) || m_axis_tready));
            check("err_tlast", 32'(err_tlast), 32'(merr));
            if (pend_fd || frame_done) check("frame_done", 32'(frame_done), 32'(pend_fd));
            if (frame_done) n_fd++;
            if (stall_pend) begin
                check("stall_valid", 32'(m_axis_tvalid), 32'd1);
                check("stall_data", 32'(m_axis_tdata), 32'(stall_data));
                check("stall_last", 32'(m_axis_tlast), 32'(stall_last));
            end
            stall_pend = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
            pend_fd = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                check("out_avail", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("out_data", 32'(m_axis_tdata), 32'(e.data));
                    check("out_last", 32'(m_axis_tlast), 32'(e.last));
                    check("sat_count", 32'(sat_count), 32'(e.sat));
                    pend_fd = e.last;
                    if (e.last) n_last++;
                end
                n_out++;
                last_out = m_axis_tdata;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (mcol == 0 && mrow == 0) mbias = cfg_bias;
                r = ref_pix(s_axis_tdata, mbias);
                if (mcol == 0 && mrow == 0) msat = {15'd0, r[16]};
                else if (msat != 16'hFFFF) msat = msat + {15'd0, r[16]};
                at_last = (mcol == W - 1) && (mrow == H - 1);
                if (s_axis_tlast != at_last) merr = 1'b1;
                e.data = r[15:0];
                e.last = at_last || s_axis_tlast;
                e.sat  = msat;
                q.push_back(e);
                if (s_axis_tlast || at_last) begin
                    mcol = 0; mrow = 0;
                end else if (mcol == W - 1) begin
                    mcol = 0; mrow = mrow + 1;
                end else begin
                    mcol = mcol + 1;
                end
            end
        end
    end

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        chk_rdy = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1 chk_rdy = 1'b1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        bit ok = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int k = 0; k < 1000; k++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(s_axis_tready), 32'd1);
        @(posedge aclk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            @(negedge aclk);
            if (q.size() == 0) break;
        end
        check("drain", 32'(q.size()), 32'd0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", ncmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int o0, l0, f0;

        // 1: reset / idle
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_ready", 32'(s_axis_tready), 32'd0);
        check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_data", 32'(m_axis_tdata), 32'd0);
        check("rst_m_last", 32'(m_axis_tlast), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err_tlast), 32'd0);
        check("rst_sat", 32'(sat_count), 32'd0);
        #2 aresetn = 1'b1;
        #1 check("rel_s_ready_pre", 32'(s_axis_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("rel_s_ready", 32'(s_axis_tready), 32'd1);
        check("rel_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk_rdy = 1'b1;

        // 2: arithmetic, two-cycle latency
        cfg_bias = 16'h0010;
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 16'h0100;
        @(negedge aclk);
        check("t2_lat0", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1 s_axis_tdata = 16'hFF00;
        @(negedge aclk);
        check("t2_lat1", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1 s_axis_tdata = 16'h7FF0;
        @(negedge aclk);
        check("t2_lat2", 32'(m_axis_tvalid), 32'd1);
        check("t2_out0", 32'(m_axis_tdata), 32'h0110);
        check("t2_sat0", 32'(sat_count), 32'd0);
        @(posedge aclk);
        #1 s_axis_tvalid = 1'b0;
        @(negedge aclk);
        check("t2_out1", 32'(m_axis_tdata), 32'hFFE2);
        @(negedge aclk);
        check("t2_out2", 32'(m_axis_tdata), 32'h7FFF);
        check("t2_sat2", 32'(sat_count), 32'd1);
        @(posedge aclk);
        #1;
        do_reset();

        // 3: full frame, no backpressure
        cfg_bias = 16'h4000;
        o0 = n_out; l0 = n_last; f0 = n_fd;
        for (int i = 0; i < NPIX; i++) send(16'($urandom), i == NPIX - 1);
        drain();
        check("t3_nout", 32'(n_out - o0), 32'(NPIX));
        check("t3_nlast", 32'(n_last - l0), 32'd1);
        check("t3_nfd", 32'(n_fd - f0), 32'd1);
        check("t3_err", 32'(err_tlast), 32'd0);

        // 4: full frame, random backpressure
        bp_mode = 1'b1;
        cfg_bias = 16'hE000;
        o0 = n_out; l0 = n_last; f0 = n_fd;
        for (int i = 0; i < NPIX; i++) send(16'($urandom), i == NPIX - 1);
        bp_mode = 1'b0;
        drain();
        check("t4_nout", 32'(n_out - o0), 32'(NPIX));
        check("t4_nlast", 32'(n_last - l0), 32'd1);
        check("t4_nfd", 32'(n_fd - f0), 32'd1);
        check("t4_err", 32'(err_tlast), 32'd0);

        // 5: early TLAST on beat 100; beat 101 starts a new frame with a new bias
        cfg_bias = 16'h0005;
        l0 = n_last; f0 = n_fd;
        for (int i = 0; i <= 100; i++) send(16'(i * 3) - 16'd150, i == 100);
        cfg_bias = 16'h0040;
        send(16'h0000, 1'b0);
        drain();
        check("t5_err", 32'(err_tlast), 32'd1);
        check("t5_nlast", 32'(n_last - l0), 32'd1);
        check("t5_nfd", 32'(n_fd - f0), 32'd1);
        check("t5_newbias", 32'(last_out), 32'h0040);

        // 6: reset mid-frame at beat 5000, then a clean frame
        do_reset();
        check("t6_err_clr", 32'(err_tlast), 32'd0);
        bp_mode = 1'b1;
        cfg_bias = 16'h1234;
        for (int i = 0; i < 5000; i++) send(16'($urandom), i == 10);
        check("t6_err_set", 32'(err_tlast), 32'd1);
        aresetn = 1'b0;
        #1;
        check("t6_rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check("t6_rst_sready", 32'(s_axis_tready), 32'd0);
        check("t6_rst_err", 32'(err_tlast), 32'd0);
        check("t6_rst_sat", 32'(sat_count), 32'd0);
        bp_mode = 1'b0;
        do_reset();
        check("t6_rel_mvalid", 32'(m_axis_tvalid), 32'd0);
        cfg_bias = 16'h8001;
        o0 = n_out; l0 = n_last; f0 = n_fd;
        for (int i = 0; i < NPIX; i++) send(16'($urandom), i == NPIX - 1);
        drain();
        check("t6_nout", 32'(n_out - o0), 32'(NPIX));
        check("t6_nlast", 32'(n_last - l0), 32'd1);
        check("t6_nfd", 32'(n_fd - f0), 32'd1);
        check("t6_err", 32'(err_tlast), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
